mpu6050_ctrl: RTL and testbench

MPU6050_CTRL -- requirements
Module: mpu6050_ctrl

---
 rtl/mpu6050_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_mpu6050_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu6050_ctrl.sv
// MPU6050 controller: wakes the sensor over I2C, then periodically burst-reads the
// six accelerometer bytes through a byte-level I2C master command/response port.
module mpu6050_ctrl #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h68,
  parameter int unsigned SAMPLE_DIV = 2500000,
  parameter logic [7:0]  PWR_REG    = 8'h6B,
  parameter logic [7:0]  PWR_VAL    = 8'h00,
  parameter logic [7:0]  DATA_REG   = 8'h3B
) (
  input  logic        dev_clk,
  input  logic        rst_n,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [7:0]  cmd_data,
  output logic        cmd_nack,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_err,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        err,
  output logic        busy
);

  localparam logic [3:0] StInitWait = 4'd0,  StWStart  = 4'd1,  StWAddr  = 4'd2,
                         StWReg     = 4'd3,  StWData   = 4'd4,  StWStop  = 4'd5,
                         StIdle     = 4'd6,  StRStart  = 4'd7,  StRAddrW = 4'd8,
                         StRReg     = 4'd9,  StRRstart = 4'd10, StRAddrR = 4'd11,
                         StRByte    = 4'd12, StRStop   = 4'd13, StPublish = 4'd14,
                         StAbort    = 4'd15;

  localparam logic [1:0] OpStart = 2'd0, OpWrite = 2'd1, OpRead = 2'd2, OpStop = 2'd3;
  localparam logic [31:0] TimerLoad = SAMPLE_DIV - 1;

  logic [3:0]      state_q, state_d;
  logic [5:0]      wait_q, wait_d;
  logic [31:0]     timer_q, timer_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic [5:0][7:0] rbuf_q, rbuf_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [1:0]      cmd_op_q, cmd_op_d;
  logic [7:0]      cmd_data_q, cmd_data_d;
  logic            cmd_nack_q, cmd_nack_d;
  logic            pending_q, pending_d;
  logic            abort_init_q, abort_init_d;
  logic [15:0]     accel_x_q, accel_x_d, accel_y_q, accel_y_d, accel_z_q, accel_z_d;
  logic            sample_valid_q, sample_valid_d;
  logic            init_done_q, init_done_d;
  logic            err_q, err_d;
  logic            rsp_hit, issue;
  logic [10:0]     next_cmd;

  // {has_command, opcode, byte} issued on entry to each state
  function automatic logic [10:0] cmd_of(input logic [3:0] st);
    case (st)
      StWStart, StRStart, StRRstart: cmd_of = {1'b1, OpStart, 8'h00};
      StWAddr, StRAddrW:             cmd_of = {1'b1, OpWrite, SLAVE_ADDR, 1'b0};
      StWReg:                        cmd_of = {1'b1, OpWrite, PWR_REG};
      StWData:                       cmd_of = {1'b1, OpWrite, PWR_VAL};
      StRReg:                        cmd_of = {1'b1, OpWrite, DATA_REG};
      StRAddrR:                      cmd_of = {1'b1, OpWrite, SLAVE_ADDR, 1'b1};
      StRByte:                       cmd_of = {1'b1, OpRead, 8'h00};
      StWStop, StRStop, StAbort:     cmd_of = {1'b1, OpStop, 8'h00};
      default:                       cmd_of = 11'h000;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    timer_d        = (timer_q != 32'd0) ? timer_q - 32'd1 : 32'd0;
    byte_cnt_d     = byte_cnt_q;
    rbuf_d         = rbuf_q;
    cmd_valid_d    = cmd_valid_q;
    cmd_op_d       = cmd_op_q;
    cmd_data_d     = cmd_data_q;
    cmd_nack_d     = cmd_nack_q;
    pending_d      = pending_q;
    abort_init_d   = abort_init_q;
    accel_x_d      = accel_x_q;
    accel_y_d      = accel_y_q;
    accel_z_d      = accel_z_q;
    sample_valid_d = 1'b0;
    init_done_d    = init_done_q;
    err_d          = 1'b0;
    issue          = 1'b0;
    next_cmd       = 11'h000;

    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
      pending_d   = 1'b1;
    end
    // Responses with nothing outstanding (e.g. left over from before a reset) are dropped
    rsp_hit = rsp_valid && pending_q;
    if (rsp_hit) pending_d = 1'b0;

    case (state_q)
      StInitWait: begin
        wait_d = wait_q + 6'd1;
        if (wait_q == 6'd63) state_d = StWStart;
      end
      StWStart:  if (rsp_hit) state_d = StWAddr;
      StWAddr:   if (rsp_hit) state_d = rsp_err ? StAbort : StWReg;
      StWReg:    if (rsp_hit) state_d = rsp_err ? StAbort : StWData;
      StWData:   if (rsp_hit) state_d = rsp_err ? StAbort : StWStop;
      StWStop: begin
        if (rsp_hit) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end
      StIdle:    if (timer_q == 32'd0) state_d = StRStart;
      StRStart:  if (rsp_hit) state_d = StRAddrW;
      StRAddrW:  if (rsp_hit) state_d = rsp_err ? StAbort : StRReg;
      StRReg:    if (rsp_hit) state_d = rsp_err ? StAbort : StRRstart;
      StRRstart: if (rsp_hit) state_d = StRAddrR;
      StRAddrR:  if (rsp_hit) state_d = rsp_err ? StAbort : StRByte;
      StRByte: begin
        if (rsp_hit) begin
          rbuf_d[byte_cnt_q] = rsp_data;
          if (byte_cnt_q == 3'd5) begin
            state_d = StRStop;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            issue      = 1'b1;
          end
        end
      end
      StRStop: begin
        if (rsp_hit) begin
          state_d        = StPublish;
          sample_valid_d = 1'b1;
          accel_x_d      = {rbuf_q[0], rbuf_q[1]};
          accel_y_d      = {rbuf_q[2], rbuf_q[3]};
          accel_z_d      = {rbuf_q[4], rbuf_q[5]};
        end
      end
      StPublish: state_d = (timer_q == 32'd0) ? StRStart : StIdle;
      StAbort: begin
        if (rsp_hit) begin
          err_d = 1'b1;
          if (abort_init_q) begin
            state_d = StInitWait;
          end else begin
            state_d = StIdle;
            timer_d = TimerLoad;
          end
        end
      end
      default: state_d = StInitWait;
    endcase

    if ((state_d == StAbort) && (state_q != StAbort)) abort_init_d = (state_q < StIdle);

    if ((state_d != state_q) || issue) begin
      if (state_d == StInitWait) wait_d = 6'd0;
      if (state_d == StRStart) begin
        timer_d    = TimerLoad;
        byte_cnt_d = 3'd0;
      end
      next_cmd = cmd_of(state_d);
      if (next_cmd[10]) begin
        cmd_valid_d = 1'b1;
        cmd_op_d    = next_cmd[9:8];
        cmd_data_d  = (next_cmd[9:8] == OpWrite) ? next_cmd[7:0] : 8'h00;
        cmd_nack_d  = (state_d == StRByte) && (byte_cnt_d == 3'd5);
      end
    end
  end

  always_ff @(posedge dev_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StInitWait;
      wait_q         <= 6'd0;
      timer_q        <= 32'd0;
      byte_cnt_q     <= 3'd0;
      rbuf_q         <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_op_q       <= 2'd0;
      cmd_data_q     <= 8'h00;
      cmd_nack_q     <= 1'b0;
      pending_q      <= 1'b0;
      abort_init_q   <= 1'b0;
      accel_x_q      <= 16'h0000;
      accel_y_q      <= 16'h0000;
      accel_z_q      <= 16'h0000;
      sample_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      timer_q        <= timer_d;
      byte_cnt_q     <= byte_cnt_d;
      rbuf_q         <= rbuf_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_op_q       <= cmd_op_d;
      cmd_data_q     <= cmd_data_d;
      cmd_nack_q     <= cmd_nack_d;
      pending_q      <= pending_d;
      abort_init_q   <= abort_init_d;
      accel_x_q      <= accel_x_d;
      accel_y_q      <= accel_y_d;
      accel_z_q      <= accel_z_d;
      sample_valid_q <= sample_valid_d;
      init_done_q    <= init_done_d;
      err_q          <= err_d;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_op       = cmd_op_q;
  assign cmd_data     = cmd_data_q;
  assign cmd_nack     = cmd_nack_q;
  assign accel_x      = accel_x_q;
  assign accel_y      = accel_y_q;
  assign accel_z      = accel_z_q;
  assign sample_valid = sample_valid_q;
  assign init_done    = init_done_q;
  assign err          = err_q;
  assign busy         = (state_q != StInitWait) && (state_q != StIdle);

endmodule

// File: tb/tb_mpu6050_ctrl.sv
// Bench for mpu6050_ctrl: an I2C-master responder model checks the command stream
// against a queue of expected commands; directed steps cover init, reads, NACKs and reset.
module tb_mpu6050_ctrl;

  logic        dev_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_nack, sample_valid, init_done, err, busy;
  logic        cmd_ready = 1'b0;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_data = 8'h00;
  logic        rsp_err = 1'b0;
  logic [15:0] accel_x, accel_y, accel_z;

  mpu6050_ctrl #(.SAMPLE_DIV(1000)) dut (
    .dev_clk(dev_clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid), .init_done(init_done), .err(err), .busy(busy)
  );

  initial forever #5 dev_clk = ~dev_clk;

  int unsigned cyc = 0;
  initial forever begin
    @(posedge dev_clk);
    cyc++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected commands as {nack, op, data}; data only meaningful for WRITE, nack for READ
  logic [10:0] exp_q[$];
  function automatic logic [10:0] mk(input logic [1:0] op, input logic [7:0] d, input logic n);
    return {n, op, d};
  endfunction

  task automatic push_init();
    exp_q.push_back(mk(2'd0, 8'h00, 1'b0));
    exp_q.push_back(mk(2'd1, 8'hD0, 1'b0));
    exp_q.push_back(mk(2'd1, 8'h6B, 1'b0));
    exp_q.push_back(mk(2'd1, 8'h00, 1'b0));
    exp_q.push_back(mk(2'd3, 8'h00, 1'b0));
  endtask

  task automatic push_read();
    exp_q.push_back(mk(2'd0, 8'h00, 1'b0));
    exp_q.push_back(mk(2'd1, 8'hD0, 1'b0));
    exp_q.push_back(mk(2'd1, 8'h3B, 1'b0));
    exp_q.push_back(mk(2'd0, 8'h00, 1'b0));
    exp_q.push_back(mk(2'd1, 8'hD1, 1'b0));
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(2'd2, 8'h00, (i == 5)));
    exp_q.push_back(mk(2'd3, 8'h00, 1'b0));
  endtask

  // Responder / slave model state
  logic [7:0]  rbytes [6];
  logic        nack_en = 1'b0, stall_en = 1'b0, inject_late = 1'b0;
  logic [7:0]  nack_byte = 8'h00;
  logic        resp_due = 1'b0, stalled = 1'b0;
  logic [10:0] cur, held, acc, exp_cmd;
  logic [1:0]  last_op = 2'd3;
  int          rd_idx = 0;
  int          rd_seen = 0;
  int unsigned start_times[$];

  initial forever begin
    @(negedge dev_clk);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    cmd_ready = 1'b0;
    if (!rst_n) begin
      resp_due = 1'b0;
      stalled  = 1'b0;
      last_op  = 2'd3;
      rd_idx   = 0;
    end else if (inject_late) begin
      rsp_valid   = 1'b1;
      rsp_data    = 8'h55;
      inject_late = 1'b0;
    end else if (resp_due) begin
      resp_due  = 1'b0;
      rsp_valid = 1'b1;
      rsp_err   = (acc[9:8] == 2'd1) && nack_en && (acc[7:0] == nack_byte);
      if (acc[9:8] == 2'd2) begin
        rsp_data = rbytes[rd_idx];
        rd_idx   = (rd_idx == 5) ? 0 : rd_idx + 1;
      end
    end else if (cmd_valid) begin
      cur = {(cmd_op == 2'd2) ? cmd_nack : 1'b0, cmd_op, (cmd_op == 2'd1) ? cmd_data : 8'h00};
      if (!stalled) begin
        if (cmd_op == 2'd0 && last_op == 2'd3) begin
          start_times.push_back(cyc);
          rd_idx = 0;
        end
        if (exp_q.size() != 0) begin
          exp_cmd = exp_q.pop_front();
          check("cmd_seq", {37'd0, cur}, {37'd0, exp_cmd});
        end
      end
      if (stall_en && !stalled) begin
        stalled = 1'b1;
        held    = cur;
      end else begin
        if (stalled) check("cmd_hold", {37'd0, cur}, {37'd0, held});
        stalled   = 1'b0;
        cmd_ready = 1'b1;
        resp_due  = 1'b1;
        acc       = cur;
        last_op   = cur[9:8];
        if (cur[9:8] == 2'd2) rd_seen++;
      end
    end
  end

  int          sv_cnt = 0, err_cnt = 0;
  int unsigned err_time = 0;
  initial forever begin
    @(negedge dev_clk);
    if (sample_valid) sv_cnt++;
    if (err) begin
      err_cnt++;
      err_time = cyc;
    end
    if (rst_n && cmd_valid) check("busy_cmd", {47'd0, busy}, 48'd1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned t0;
  int          n0, e0;

  initial begin
    rbytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC0, 8'hDE};
    repeat (3) @(negedge dev_clk);
    check("rst_cmd", {36'd0, cmd_valid, cmd_op, cmd_data, cmd_nack}, 48'd0);
    check("rst_flags", {44'd0, sample_valid, init_done, err, busy}, 48'd0);
    check("rst_accel", {accel_x, accel_y, accel_z}, 48'd0);

    // Init then first read, with every command stalled one cycle by the master
    stall_en = 1'b1;
    push_init();
    push_read();
    rst_n = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 200 && !cmd_valid; i++) @(negedge dev_clk);
    check("init_delay", 48'(cyc - t0), 48'd64);
    for (int i = 0; i < 200 && !init_done; i++) @(negedge dev_clk);
    check("init_done", {47'd0, init_done}, 48'd1);
    @(negedge dev_clk);
    check("first_rd_start", {45'd0, cmd_valid, cmd_op}, {45'd0, 1'b1, 2'd0});
    for (int i = 0; i < 300 && sv_cnt < 1; i++) @(negedge dev_clk);
    check("rd1_accel", {accel_x, accel_y, accel_z}, 48'hDEAD_BEEF_C0DE);
    repeat (5) @(negedge dev_clk);
    check("rd1_sv_once", 48'(sv_cnt), 48'd1);
    check("rd1_drain", 48'(exp_q.size()), 48'd0);
    check("rd1_no_err", 48'(err_cnt), 48'd0);

    // Periodicity with an instant responder
    stall_en = 1'b0;
    rbytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    n0 = start_times.size();
    for (int i = 0; i < 2500 && start_times.size() < n0 + 2; i++) @(negedge dev_clk);
    check("period_cnt", 48'(start_times.size()), 48'(n0 + 2));
    if (start_times.size() >= n0 + 2) begin
      check("period_1", 48'(start_times[n0] - start_times[n0-1]), 48'd1000);
      check("period_2", 48'(start_times[n0+1] - start_times[n0]), 48'd1000);
    end
    for (int i = 0; i < 300 && sv_cnt < 3; i++) @(negedge dev_clk);
    check("rd3_accel", {accel_x, accel_y, accel_z}, 48'h1234_5678_9ABC);

    // Read-phase NACK on the read address byte
    nack_byte = 8'hD1;
    nack_en = 1'b1;
    exp_q.push_back(mk(2'd0, 8'h00, 1'b0));
    exp_q.push_back(mk(2'd1, 8'hD0, 1'b0));
    exp_q.push_back(mk(2'd1, 8'h3B, 1'b0));
    exp_q.push_back(mk(2'd0, 8'h00, 1'b0));
    exp_q.push_back(mk(2'd1, 8'hD1, 1'b0));
    exp_q.push_back(mk(2'd3, 8'h00, 1'b0));
    e0 = err_cnt;
    for (int i = 0; i < 1500 && err_cnt == e0; i++) @(negedge dev_clk);
    check("rnack_idle_busy", {47'd0, busy}, 48'd0);
    nack_en = 1'b0;
    repeat (5) @(negedge dev_clk);
    check("rnack_err_once", 48'(err_cnt), 48'(e0 + 1));
    check("rnack_no_sv", 48'(sv_cnt), 48'd3);
    check("rnack_accel_hold", {accel_x, accel_y, accel_z}, 48'h1234_5678_9ABC);
    check("rnack_drain", 48'(exp_q.size()), 48'd0);
    n0 = start_times.size();
    for (int i = 0; i < 1200 && start_times.size() == n0; i++) @(negedge dev_clk);
    check("rnack_restart", 48'(start_times[start_times.size()-1] - err_time), 48'd1000);

    // Init-phase NACK on the write address byte, then retry
    rst_n = 1'b0;
    repeat (2) @(negedge dev_clk);
    nack_byte = 8'hD0;
    nack_en = 1'b1;
    exp_q.push_back(mk(2'd0, 8'h00, 1'b0));
    exp_q.push_back(mk(2'd1, 8'hD0, 1'b0));
    exp_q.push_back(mk(2'd3, 8'h00, 1'b0));
    e0 = err_cnt;
    rst_n = 1'b1;
    for (int i = 0; i < 300 && err_cnt == e0; i++) @(negedge dev_clk);
    check("inack_err", 48'(err_cnt), 48'(e0 + 1));
    check("inack_no_init", {47'd0, init_done}, 48'd0);
    check("inack_drain", 48'(exp_q.size()), 48'd0);
    nack_en = 1'b0;
    push_init();
    n0 = start_times.size();
    for (int i = 0; i < 200 && start_times.size() == n0; i++) @(negedge dev_clk);
    check("inack_retry", 48'(start_times[start_times.size()-1] - err_time), 48'd64);
    for (int i = 0; i < 200 && !init_done; i++) @(negedge dev_clk);
    check("inack_init_done", {47'd0, init_done}, 48'd1);
    check("inack_retry_drain", 48'(exp_q.size()), 48'd0);

    // Reset during the third READ of a burst, with a stray late response afterwards
    for (int i = 0; i < 300 && sv_cnt < 4; i++) @(negedge dev_clk);
    check("pre_reset_accel", {accel_x, accel_y, accel_z}, 48'h1234_5678_9ABC);
    n0 = rd_seen;
    for (int i = 0; i < 1500 && rd_seen < n0 + 3; i++) @(negedge dev_clk);
    @(negedge dev_clk);
    rst_n = 1'b0;
    @(negedge dev_clk);
    check("mrst_cmd", {36'd0, cmd_valid, cmd_op, cmd_data, cmd_nack}, 48'd0);
    check("mrst_flags", {44'd0, sample_valid, init_done, err, busy}, 48'd0);
    check("mrst_accel", {accel_x, accel_y, accel_z}, 48'd0);
    repeat (2) @(negedge dev_clk);
    e0 = err_cnt;
    push_init();
    rst_n = 1'b1;
    t0 = cyc;
    inject_late = 1'b1;
    for (int i = 0; i < 200 && !cmd_valid; i++) @(negedge dev_clk);
    check("mrst_init_delay", 48'(cyc - t0), 48'd64);
    for (int i = 0; i < 200 && !init_done; i++) @(negedge dev_clk);
    check("mrst_init_done", {47'd0, init_done}, 48'd1);
    check("mrst_drain", 48'(exp_q.size()), 48'd0);
    check("mrst_no_err", 48'(err_cnt), 48'(e0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
